inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/core_pkg.sv | 69 ++++++
 rtl/inst_pack.sv | 26 ++
 rtl/inst_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_inst_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// bit-field offsets, default layer geometry and the decoded control bundle.
package core_pkg;

  localparam int          ROW_DEF      = 8;
  localparam int          COL_DEF      = 8;
  localparam int          LEN_NIJ_DEF  = 36;
  localparam int          LEN_KIJ_DEF  = 9;
  localparam int          LEN_ONIJ_DEF = 16;
  localparam int          GAP_DEF      = 10;
  localparam logic [10:0] W_BASE_DEF   = 11'h400;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;
  localparam int IDX_W  = 8;

  localparam int INST_MODE     = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_P    = 32;
  localparam int INST_WEN_P    = 31;
  localparam int INST_AP_LO    = 20;
  localparam int INST_CEN_X    = 19;
  localparam int INST_WEN_X    = 18;
  localparam int INST_AX_LO    = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXEC     = 1;
  localparam int INST_LOAD     = 0;

  // Inactive instruction word: both memories deselected and not writing.
  localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << INST_CEN_P) |
                                            (INST_W'(1) << INST_WEN_P) |
                                            (INST_W'(1) << INST_CEN_X) |
                                            (INST_W'(1) << INST_WEN_X);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_X_L0, S_EXEC, S_DRAIN,
    S_WAIT_OV, S_OF_RD, S_ACC_RD, S_ACC_OUT, S_GAP
  } state_t;

  typedef struct packed {
    logic              mode;
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mode: 1'b0, acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1,
                                  a_pmem: '0, cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: '0,
                                  ofifo_rd: 1'b0, l0_rd: 1'b0, l0_wr: 1'b0,
                                  execute: 1'b0, load: 1'b0};

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Packs the decoded control bundle into the 35-bit core instruction word.
module inst_pack
  import core_pkg::*;
(
  input  ctrl_t              ctrl_i,
  output logic [INST_W-1:0]  inst_o
);

  always_comb begin
    inst_o                            = '0;
    inst_o[INST_MODE]                 = ctrl_i.mode;
    inst_o[INST_ACC]                  = ctrl_i.acc;
    inst_o[INST_CEN_P]                = ctrl_i.cen_pmem;
    inst_o[INST_WEN_P]                = ctrl_i.wen_pmem;
    inst_o[INST_AP_LO +: ADDR_W]      = ctrl_i.a_pmem;
    inst_o[INST_CEN_X]                = ctrl_i.cen_xmem;
    inst_o[INST_WEN_X]                = ctrl_i.wen_xmem;
    inst_o[INST_AX_LO +: ADDR_W]      = ctrl_i.a_xmem;
    inst_o[INST_OFIFO_RD]             = ctrl_i.ofifo_rd;
    inst_o[INST_L0_RD]                = ctrl_i.l0_rd;
    inst_o[INST_L0_WR]                = ctrl_i.l0_wr;
    inst_o[INST_EXEC]                 = ctrl_i.execute;
    inst_o[INST_LOAD]                 = ctrl_i.load;
  end

endmodule

// File: rtl/inst_sequencer.sv
// Layer sequencer: walks weight load, activation load, execute, psum write-back
// per kernel position, then accumulates each output pixel from pmem.
module inst_sequencer
  import core_pkg::*;
#(
  parameter int          row      = ROW_DEF,
  parameter int          col      = COL_DEF,
  parameter int          len_nij  = LEN_NIJ_DEF,
  parameter int          len_kij  = LEN_KIJ_DEF,
  parameter int          len_onij = LEN_ONIJ_DEF,
  parameter int          gap      = GAP_DEF,
  parameter logic [10:0] w_base   = W_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              ofifo_valid,
  output logic [IDX_W-1:0]  acc_idx,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              out_valid,
  output logic              done,
  output state_t            state_dbg
);

  localparam int CNT_MAX = max_of(max_of(col, len_nij), max_of(row + col, max_of(gap, len_kij + 1)));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int KIJ_W   = $clog2(len_kij + 1);
  localparam int ONIJ_W  = $clog2(len_onij + 1);

  state_t              state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [KIJ_W-1:0]    kij_q, kij_d;
  logic [ONIJ_W-1:0]   onij_q, onij_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]    acc_base_q, acc_base_d;
  logic                mode_q, mode_d, busy_q, busy_d, ov_q, ov_d, done_q, done_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  ctrl_t               ctrl;

  assign cnt_inc = cnt_q + CNT_W'(1);

  inst_pack u_pack (.ctrl_i(ctrl), .inst_o(inst_d));

  // start is a request with no back-pressure: it is taken only in IDLE and
  // busy acknowledges it from the next cycle until the done pulse.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    kij_d      = kij_q;
    onij_d     = onij_q;
    ptr_d      = ptr_q;
    acc_base_d = acc_base_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    ov_d       = 1'b0;
    done_d     = 1'b0;
    acc_idx    = '0;
    ctrl       = CTRL_IDLE;
    ctrl.mode  = (state_q == S_IDLE) ? 1'b0 : mode_q;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_W_L0;
        cnt_d   = '0;
        kij_d   = '0;
        ptr_d   = '0;
        mode_d  = mode;
        busy_d  = 1'b1;
      end
      S_W_L0: begin
        ctrl.cen_xmem = 1'b0;
        ctrl.l0_wr    = 1'b1;
        ctrl.a_xmem   = w_base + ADDR_W'(cnt_q);
        if (cnt_q == CNT_W'(col - 1)) begin
          cnt_d = '0; ret_d = S_W_LOAD; state_d = S_GAP;
        end else cnt_d = cnt_inc;
      end
      S_W_LOAD: begin
        ctrl.l0_rd = 1'b1;
        ctrl.load  = 1'b1;
        if (cnt_q == CNT_W'(col - 1)) begin
          cnt_d = '0; ret_d = S_X_L0; state_d = S_GAP;
        end else cnt_d = cnt_inc;
      end
      S_X_L0: begin
        ctrl.cen_xmem = 1'b0;
        ctrl.l0_wr    = 1'b1;
        ctrl.a_xmem   = ADDR_W'(cnt_q);
        if (cnt_q == CNT_W'(len_nij - 1)) begin
          cnt_d = '0; ret_d = S_EXEC; state_d = S_GAP;
        end else cnt_d = cnt_inc;
      end
      S_EXEC: begin
        ctrl.l0_rd   = 1'b1;
        ctrl.execute = 1'b1;
        if (cnt_q == CNT_W'(len_nij - 1)) begin
          cnt_d = '0; state_d = S_DRAIN;
        end else cnt_d = cnt_inc;
      end
      S_DRAIN: begin
        ctrl.l0_rd   = 1'b1;
        ctrl.execute = 1'b1;
        if (cnt_q == CNT_W'(row + col - 1)) begin
          cnt_d = '0; state_d = S_WAIT_OV;
        end else cnt_d = cnt_inc;
      end
      S_WAIT_OV: if (ofifo_valid) state_d = S_OF_RD;
      S_OF_RD: begin
        ctrl.ofifo_rd = 1'b1;
        ctrl.cen_pmem = 1'b0;
        ctrl.wen_pmem = 1'b0;
        ctrl.a_pmem   = ptr_q;
        ptr_d         = ptr_q + ADDR_W'(1);
        if (cnt_q == CNT_W'(len_nij - 1)) begin
          cnt_d = '0;
          kij_d = kij_q + KIJ_W'(1);
          if (kij_q == KIJ_W'(len_kij - 1)) begin
            onij_d = '0; acc_base_d = '0; state_d = S_ACC_RD;
          end else begin
            ret_d = S_W_L0; state_d = S_GAP;
          end
        end else cnt_d = cnt_inc;
      end
      S_ACC_RD: begin
        // The read issued at j-1 lands at j, so accumulate from j=1 through the
        // trailing cycle that only drains the last read.
        ctrl.acc = (cnt_q != '0);
        if (cnt_q < CNT_W'(len_kij)) begin
          ctrl.cen_pmem = 1'b0;
          acc_idx       = acc_base_q + IDX_W'(cnt_q);
          ctrl.a_pmem   = acc_addr;
          cnt_d         = cnt_inc;
        end else begin
          cnt_d = '0; state_d = S_ACC_OUT;
        end
      end
      S_ACC_OUT: begin
        ov_d = 1'b1;
        if (onij_q == ONIJ_W'(len_onij - 1)) begin
          done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
        end else begin
          onij_d     = onij_q + ONIJ_W'(1);
          acc_base_d = acc_base_q + IDX_W'(len_kij);
          state_d    = S_ACC_RD;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(gap - 1)) begin
          cnt_d = '0; state_d = ret_q;
        end else cnt_d = cnt_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      cnt_q      <= '0;
      kij_q      <= '0;
      onij_q     <= '0;
      ptr_q      <= '0;
      acc_base_q <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      ov_q       <= 1'b0;
      done_q     <= 1'b0;
      inst_q     <= INST_IDLE;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      kij_q      <= kij_d;
      onij_q     <= onij_d;
      ptr_q      <= ptr_d;
      acc_base_q <= acc_base_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      ov_q       <= ov_d;
      done_q     <= done_d;
      inst_q     <= inst_d;
    end
  end

  assign inst      = inst_q;
  assign busy      = busy_q;
  assign out_valid = ov_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: a phase-level model expands each layer run into
// per-cycle expected {done, out_valid, busy, inst} entries checked every cycle.
module tb_inst_sequencer;
  import core_pkg::*;

  localparam int          ROWS = 8, COLS = 8, NIJ = 36, KIJ = 9, ONIJ = 16, GAPC = 10;
  localparam logic [10:0] WB   = 11'h400;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;
  localparam int          EW   = 39;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [7:0]  acc_idx;
  logic [10:0] acc_addr;
  logic [34:0] inst;
  logic        busy, out_valid, done;
  state_t      state_dbg;
  bit          rom_sel = 1'b0, ofv_hold = 1'b0, prev_ofv = 1'b0;
  int          wait_run = 0, n_chk = 0, n_pass = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ofifo_valid(ofifo_valid),
    .acc_idx(acc_idx), .acc_addr(acc_addr), .inst(inst), .busy(busy),
    .out_valid(out_valid), .done(done), .state_dbg(state_dbg)
  );

  function automatic logic [10:0] rom_f(input logic [7:0] idx, input bit sel);
    return sel ? 11'(int'(idx) * 7 + 3) : {3'b000, idx};
  endfunction

  assign acc_addr = rom_f(acc_idx, rom_sel);

  // ofifo_valid: tied high, or raised only after 50 observed wait cycles.
  always @(posedge clk) begin
    #1;
    ofifo_valid = ofv_hold ? (wait_run >= 50) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- model ----------------
  function automatic logic [34:0] mk(input logic m, acc, cenp, wenp, input logic [10:0] ap,
                                     input logic cenx, wenx, input logic [10:0] ax,
                                     input logic ofrd, l0rd, l0wr, exe, ld);
    return {m, acc, cenp, wenp, ap, cenx, wenx, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
  endfunction

  function automatic logic [34:0] inact(input logic m);
    return mk(m, 0, 1, 1, '0, 1, 1, '0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input logic [34:0] w, input logic b, ov, dn, wmk);
    exp_q.push_back({wmk, dn, ov, b, w});
  endtask

  task automatic push_gap(input logic m);
    for (int g = 0; g < GAPC; g++) push(inact(m), 1, 0, 0, 0);
  endtask

  task automatic push_run(input logic m, input bit rs);
    push(inact(1'b0), 1, 0, 0, 0);
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < COLS; i++) push(mk(m, 0, 1, 1, '0, 0, 1, WB + 11'(i), 0, 0, 1, 0, 0), 1, 0, 0, 0);
      push_gap(m);
      for (int i = 0; i < COLS; i++) push(mk(m, 0, 1, 1, '0, 1, 1, '0, 0, 1, 0, 0, 1), 1, 0, 0, 0);
      push_gap(m);
      for (int i = 0; i < NIJ; i++) push(mk(m, 0, 1, 1, '0, 0, 1, 11'(i), 0, 0, 1, 0, 0), 1, 0, 0, 0);
      push_gap(m);
      for (int i = 0; i < NIJ + ROWS + COLS; i++) push(mk(m, 0, 1, 1, '0, 1, 1, '0, 0, 1, 0, 1, 0), 1, 0, 0, 0);
      push(inact(m), 1, 0, 0, 1);
      for (int n = 0; n < NIJ; n++) push(mk(m, 0, 0, 0, 11'(k * NIJ + n), 1, 1, '0, 1, 0, 0, 0, 0), 1, 0, 0, 0);
      if (k < KIJ - 1) push_gap(m);
    end
    for (int o = 0; o < ONIJ; o++) begin
      for (int j = 0; j < KIJ; j++)
        push(mk(m, j >= 1, 0, 1, rom_f(8'(o * KIJ + j), rs), 1, 1, '0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
      push(mk(m, 1, 1, 1, '0, 1, 1, '0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
      push(inact(m), o != ONIJ - 1, 1, o == ONIJ - 1, 0);
    end
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    e = (exp_q.size() == 0) ? {4'b0000, inact(1'b0)} : exp_q[0];
    chk("cycle", 64'({done, out_valid, busy, inst}), 64'(e[37:0]));
    if (e[38]) begin
      if (prev_ofv) begin
        void'(exp_q.pop_front());
        wait_run = 0;
      end else begin
        wait_run++;
        chk("wait_state", 64'(state_dbg), 64'(S_WAIT_OV));
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    prev_ofv = ofifo_valid;
  end

  // ---------------- event monitor for literal pins ----------------
  int load_first, pw_cnt, ov_cnt, done_cnt, mode1_cnt;
  int acc_hi[0:16];
  bit seen_ofrd, busy_at_done;
  logic [10:0] last_pw;
  logic [10:0] rd_q[$];

  task automatic clr_mon();
    load_first = 0; pw_cnt = 0; ov_cnt = 0; done_cnt = 0; mode1_cnt = 0;
    seen_ofrd = 0; busy_at_done = 1; last_pw = '0; rd_q.delete();
    for (int i = 0; i <= 16; i++) acc_hi[i] = 0;
  endtask

  always @(negedge clk) begin
    if (inst[0] && !seen_ofrd) load_first++;
    if (inst[6]) seen_ofrd = 1;
    if (!inst[32] && !inst[31]) begin last_pw = inst[30:20]; pw_cnt++; end
    if (!inst[32] && inst[31]) rd_q.push_back(inst[30:20]);
    if (inst[33] && ov_cnt <= 16) acc_hi[ov_cnt]++;
    if (inst[34]) mode1_cnt++;
    if (out_valid) ov_cnt++;
    if (done) begin done_cnt++; busy_at_done = busy; end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic m, input bit rs);
    @(posedge clk); #1 start = 1'b1; mode = m;
    @(posedge clk); #1 start = 1'b0;
    push_run(m, rs);
  endtask

  task automatic run_wait(input bit tog, input bit poke, input bit rst_ofrd);
    bit poked;
    bit fin;
    poked = 0;
    fin = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (start) start = 1'b0;
      if (tog) mode = ~mode;
      if (poke && !poked && inst[1]) begin start = 1'b1; poked = 1; end
      if (rst_ofrd && inst[6]) begin
        reset = 1'b0;
        exp_q.delete();
        wait_run = 0;
        #1;
        chk("rst_mid_inst", 64'(inst), 64'(IDLE_W));
        chk("rst_mid_flags", 64'({busy, out_valid, done}), 64'(0));
        chk("rst_mid_state", 64'(state_dbg), 64'(S_IDLE));
        chk("rst_mid_acc_idx", 64'(acc_idx), 64'(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        fin = 1;
        break;
      end
      if (exp_q.size() == 0) begin fin = 1; break; end
    end
    chk("run_finished", 64'(fin), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clr_mon();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_inst", 64'(inst), 64'(IDLE_W));
    chk("reset_flags", 64'({busy, out_valid, done}), 64'(0));

    // Run 1: OS mode, ofifo_valid tied high, identity ROM, stray start in EXEC.
    clr_mon();
    rom_sel = 1'b0;
    issue_start(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("w_l0_a_xmem", 64'(inst[17:7]), 64'(11'h400));
    chk("w_l0_l0_wr", 64'(inst[2]), 64'(1));
    chk("w_l0_cen_xmem", 64'(inst[19]), 64'(0));
    run_wait(1'b0, 1'b1, 1'b0);
    chk("load_first_pass", 64'(load_first), 64'(8));
    chk("pmem_writes", 64'(pw_cnt), 64'(324));
    chk("last_pmem_wr", 64'(last_pw), 64'(323));
    chk("out_valid_pulses", 64'(ov_cnt), 64'(16));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("busy_at_done", 64'(busy_at_done), 64'(0));
    chk("acc_hi_onij3", 64'(acc_hi[3]), 64'(9));
    chk("acc_reads", 64'(rd_q.size()), 64'(144));
    chk("rd_onij3_first", 64'(rd_q.size() > 35 ? rd_q[27] : 11'h7ff), 64'(27));
    chk("rd_onij3_last", 64'(rd_q.size() > 35 ? rd_q[35] : 11'h7ff), 64'(35));

    // Run 2: WS mode, mode toggling mid-run, ofifo_valid withheld 50 cycles.
    clr_mon();
    ofv_hold = 1'b1;
    issue_start(1'b0, 1'b0);
    run_wait(1'b1, 1'b0, 1'b0);
    ofv_hold = 1'b0;
    chk("ws_mode_bit", 64'(mode1_cnt), 64'(0));
    chk("ws_pmem_writes", 64'(pw_cnt), 64'(324));

    // Run 3: reset asserted during the first OF_RD phase.
    clr_mon();
    rom_sel = 1'b1;
    issue_start(1'b1, 1'b1);
    run_wait(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);

    // Run 4: full run after reset release, scrambled ROM.
    clr_mon();
    issue_start(1'b1, 1'b1);
    run_wait(1'b0, 1'b0, 1'b0);
    chk("r4_out_valid_pulses", 64'(ov_cnt), 64'(16));
    chk("r4_done_pulses", 64'(done_cnt), 64'(1));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
